ci_dot_initiator: RTL and testbench
===================================

Name: ci_dot_initiator

Overview:
- Initiator side of the Nios custom-instruction (CI) handshake. Drives `ci_start`, `ci_n`, `ci_dataa` and `ci_datab` into a multi-cycle CI multiply-accumulate responder and waits for `ci_done`.
- Computes a dot product over a streamed vector of operand pairs without CPU involvement, then returns the 32-bit result on a valid/ready output.
- Sits between a DMA/stream source and the MAC CI slave, so the slave can be exercised in hardware.

Parameters:
- DATA_W, 32, operand/result width.
- LEN_W, 16, job length counter width.
- TMO_CYC, 255, max cycles to wait for `ci_done` after a start pulse (1..255).

Ports:
- clk  in  1  system clock
- reset_n  in  1  asynchronous active-low reset
- job_valid  in  1  job request valid
- job_ready  out  1  block can accept a job
- job_len  in  LEN_W  number of element pairs in job
- elem_valid  in  1  operand pair valid
- elem_ready  out  1  operand pair accepted
- elem_a  in  DATA_W  operand A
- elem_b  in  DATA_W  operand B
- res_valid  out  1  result valid
- res_ready  in  1  result consumer ready
- res_data  out  DATA_W  dot product (low DATA_W bits)
- res_err  out  1  job aborted on CI timeout
- ci_clk_en  out  1  CI clock enable
- ci_start  out  1  CI start pulse
- ci_n  out  8  CI opcode: 1=MAC, 2=READ+CLEAR, 3=LOAD-MUL
- ci_dataa  out  DATA_W  CI operand A
- ci_datab  out  DATA_W  CI operand B
- ci_done  in  1  CI completion
- ci_result  in  DATA_W  CI result, valid while `ci_done`=1

Behaviour:
- **Reset:** one clock, `clk`; reset is asynchronous and active-low (`reset_n`).
  - On reset: state=IDLE, every output 0, counters 0.
  - Reset mid-job abandons the job; no result is emitted.
- **States:** IDLE, FETCH, ISSUE, WAIT, RD_ISSUE, RD_WAIT, DRAIN, OUTPUT.
- **IDLE:**
  - `job_ready`=1. On `job_valid`&`job_ready`, latch `job_len` into `remain` and set `first`=1.
  - If `job_len`=0: go to OUTPUT with `res_data`=0, `res_err`=0, and issue no CI traffic.
  - Otherwise go to FETCH.
- **FETCH:**
  - `elem_ready`=1. On `elem_valid`, latch a/b into `ci_dataa`/`ci_datab`.
  - Set `ci_n`=3 if `first`, else 1. Go to ISSUE.
- **ISSUE:**
  - `ci_start`=1 and `ci_clk_en`=1 for exactly one cycle.
  - Clear the timeout counter. Go to WAIT.
- **WAIT:**
  - `ci_start`=0. Operands and `ci_n` stay stable until `ci_done`.
  - On `ci_done`: decrement `remain`, clear `first`. Go to RD_ISSUE if `remain` becomes 0, else FETCH.
  - If the counter reaches TMO_CYC without `ci_done`: set `res_err`=1, `res_data`=0, decrement `remain`. Go to DRAIN if `remain`≠0, else OUTPUT.
- **RD_ISSUE:** `ci_n`=2, `ci_dataa`=`ci_datab`=0, one-cycle `ci_start`. Go to RD_WAIT.
- **RD_WAIT:**
  - On `ci_done`, capture `ci_result` into `res_data`. Go to OUTPUT.
  - On timeout, behave as in WAIT; `remain` is already 0, so go to OUTPUT.
- **DRAIN:** `elem_ready`=1. Consume and discard the remaining `remain` pairs to keep the stream aligned, then go to OUTPUT.
- **OUTPUT:**
  - `res_valid`=1; `res_data`/`res_err` are held stable.
  - On `res_ready`, clear `res_valid` and `res_err`. Go to IDLE.
- **Handshake rules:**
  - Exactly one outstanding CI transaction; no new start before `ci_done` or timeout.
  - A `ci_done` arriving in the same cycle as `ci_start` is ignored. The responder asserts done the cycle after start at the earliest.
  - A `ci_done` seen outside WAIT/RD_WAIT is ignored.
  - `ci_done` in the same cycle as counter expiry counts as success.
  - `job_ready`=0 and `elem_ready`=0 outside the states listed above.
  - `ci_clk_en` is asserted only with `ci_start`.
- **Arithmetic:** `remain` counts down to 0 (no wrap). The timeout counter saturates. Result is the responder's 32-bit wrap-around value, passed through unmodified.
- **Throughput:** minimum 3 cycles per element (FETCH, ISSUE, WAIT with done the next cycle), plus 2 cycles read and 1+ output.

Decomposition:
- Package `ci_pkg`:
  - opcode constants `CI_OP_MAC`=1, `CI_OP_READ`=2, `CI_OP_MUL`=3
  - state enum
  - `CI_N_W`=8
- Sub-module `ci_watchdog`: a loadable saturating counter with clear/enable and an `expired` flag. It is shared with future CI initiators.

Test Plan:
- Job len=3, pairs (2,3),(4,5),(−1,7), responder done at +1 cycle → CI ops 3,1,1,2 in order; `res_data`=19, `res_err`=0.
- Job len=0 → no `ci_start` ever; `res_valid` with `res_data`=0 one cycle after job accept.
- Job len=2, pairs (0x10000,0x10000),(1,1) → `res_data`=1 (wrap-around); `ci_n` and operands stable across a 5-cycle delayed `ci_done`.
- Job len=4, responder never asserts done on element 2 → timeout after 255 cycles; elements 3–4 drained; `res_err`=1, `res_data`=0; next job len=1 pair (6,7) → 42.
- `res_ready` held low 10 cycles → `res_valid`/`res_data` stable; `job_ready`=0 throughout.
- `reset_n` pulsed low during WAIT → all outputs 0 asynchronously; after release, job len=1 (3,3) → 9.

Source files
------------

// File: rtl/ci_pkg.sv
// ============================================================================
// Module      : ci_pkg
// Description : Shared opcodes and state encoding for CI initiators.
// Revision    : 1.0
// ============================================================================
`default_nettype none

package ci_pkg;

    localparam int CI_N_W = 8;

    localparam logic [CI_N_W-1:0] CI_OP_MAC  = 8'd1;
    localparam logic [CI_N_W-1:0] CI_OP_READ = 8'd2;
    localparam logic [CI_N_W-1:0] CI_OP_MUL  = 8'd3;

    typedef logic [2:0] ci_state_t;

    localparam ci_state_t ST_IDLE     = 3'd0;
    localparam ci_state_t ST_FETCH    = 3'd1;
    localparam ci_state_t ST_ISSUE    = 3'd2;
    localparam ci_state_t ST_WAIT     = 3'd3;
    localparam ci_state_t ST_RD_ISSUE = 3'd4;
    localparam ci_state_t ST_RD_WAIT  = 3'd5;
    localparam ci_state_t ST_DRAIN    = 3'd6;
    localparam ci_state_t ST_OUTPUT   = 3'd7;

endpackage

`default_nettype wire

// File: rtl/ci_watchdog.sv
// ============================================================================
// Module      : ci_watchdog
// Description : Loadable saturating counter with clear/enable and expiry flag.
// Revision    : 1.0
// ============================================================================
`default_nettype none

module ci_watchdog #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             clr,
    input  logic             en,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic [WIDTH-1:0] limit,
    output logic             expired
);

    logic [WIDTH-1:0] r_count;

    // Clear dominates load; counting stops once the limit is reached.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_count <= '0;
        end else if (clr) begin
            r_count <= '0;
        end else if (load) begin
            r_count <= load_val;
        end else if (en && (r_count < limit)) begin
            r_count <= r_count + 1'b1;
        end
    end

    assign expired = (r_count >= limit);

endmodule

`default_nettype wire

// File: rtl/ci_dot_initiator.sv
// ============================================================================
// Module      : ci_dot_initiator
// Description : Streams operand pairs into a CI MAC responder, returns the dot product.
// Revision    : 1.0
// ============================================================================
`default_nettype none

module ci_dot_initiator
    import ci_pkg::*;
#(
    parameter int DATA_W  = 32,
    parameter int LEN_W   = 16,
    parameter int TMO_CYC = 255
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              job_valid,
    output logic              job_ready,
    input  logic [LEN_W-1:0]  job_len,
    input  logic              elem_valid,
    output logic              elem_ready,
    input  logic [DATA_W-1:0] elem_a,
    input  logic [DATA_W-1:0] elem_b,
    output logic              res_valid,
    input  logic              res_ready,
    output logic [DATA_W-1:0] res_data,
    output logic              res_err,
    output logic              ci_clk_en,
    output logic              ci_start,
    output logic [CI_N_W-1:0] ci_n,
    output logic [DATA_W-1:0] ci_dataa,
    output logic [DATA_W-1:0] ci_datab,
    input  logic              ci_done,
    input  logic [DATA_W-1:0] ci_result
);

    localparam logic [7:0]       c_tmo_limit = 8'(TMO_CYC);
    localparam logic [LEN_W-1:0] c_one       = LEN_W'(1);

    ci_state_t        r_state;
    logic [LEN_W-1:0] r_remain;
    logic             r_first;
    logic             r_live;
    logic             w_wd_expired;

    // r_live keeps job_ready low while reset is asserted and for the cycle after.
    assign job_ready  = r_live && (r_state == ST_IDLE);
    assign elem_ready = (r_state == ST_FETCH) || (r_state == ST_DRAIN);
    assign ci_start   = (r_state == ST_ISSUE) || (r_state == ST_RD_ISSUE);
    assign ci_clk_en  = ci_start;
    assign res_valid  = (r_state == ST_OUTPUT);

    ci_watchdog #(
        .WIDTH (8)
    ) u_watchdog (
        .clk      (clk),
        .reset_n  (reset_n),
        .clr      (ci_start),
        .en       ((r_state == ST_WAIT) || (r_state == ST_RD_WAIT)),
        .load     (1'b0),
        .load_val (8'd0),
        .limit    (c_tmo_limit),
        .expired  (w_wd_expired)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state  <= ST_IDLE;
            r_live   <= 1'b0;
            r_remain <= '0;
            r_first  <= 1'b0;
            ci_n     <= '0;
            ci_dataa <= '0;
            ci_datab <= '0;
            res_data <= '0;
            res_err  <= 1'b0;
        end else begin
            r_live <= 1'b1;
            case (r_state)
                ST_IDLE: begin
                    if (job_valid && job_ready) begin
                        r_remain <= job_len;
                        r_first  <= 1'b1;
                        res_err  <= 1'b0;
                        if (job_len == '0) begin
                            res_data <= '0;
                            r_state  <= ST_OUTPUT;
                        end else begin
                            r_state  <= ST_FETCH;
                        end
                    end
                end
                ST_FETCH: begin
                    if (elem_valid) begin
                        ci_dataa <= elem_a;
                        ci_datab <= elem_b;
                        ci_n     <= r_first ? CI_OP_MUL : CI_OP_MAC;
                        r_state  <= ST_ISSUE;
                    end
                end
                ST_ISSUE: r_state <= ST_WAIT;
                ST_WAIT: begin
                    // Done wins over a coincident expiry.
                    if (ci_done) begin
                        r_remain <= r_remain - 1'b1;
                        r_first  <= 1'b0;
                        if (r_remain == c_one) begin
                            ci_n     <= CI_OP_READ;
                            ci_dataa <= '0;
                            ci_datab <= '0;
                            r_state  <= ST_RD_ISSUE;
                        end else begin
                            r_state  <= ST_FETCH;
                        end
                    end else if (w_wd_expired) begin
                        res_err  <= 1'b1;
                        res_data <= '0;
                        r_remain <= r_remain - 1'b1;
                        r_state  <= (r_remain == c_one) ? ST_OUTPUT : ST_DRAIN;
                    end
                end
                ST_RD_ISSUE: r_state <= ST_RD_WAIT;
                ST_RD_WAIT: begin
                    if (ci_done) begin
                        res_data <= ci_result;
                        r_state  <= ST_OUTPUT;
                    end else if (w_wd_expired) begin
                        res_err  <= 1'b1;
                        res_data <= '0;
                        r_state  <= ST_OUTPUT;
                    end
                end
                ST_DRAIN: begin
                    // Discard the pairs of an aborted job so the stream stays aligned.
                    if (r_remain == '0) begin
                        r_state <= ST_OUTPUT;
                    end else if (elem_valid) begin
                        r_remain <= r_remain - 1'b1;
                        if (r_remain == c_one) begin
                            r_state <= ST_OUTPUT;
                        end
                    end
                end
                ST_OUTPUT: begin
                    if (res_ready) begin
                        res_err <= 1'b0;
                        r_state <= ST_IDLE;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_ci_dot_initiator.sv
// ============================================================================
// Module      : tb_ci_dot_initiator
// Description : Scoreboard bench for ci_dot_initiator with a behavioural MAC responder.
// Revision    : 1.0
// ============================================================================
`default_nettype none

module tb_ci_dot_initiator;

    localparam int DATA_W = 32;
    localparam int LEN_W  = 16;
    localparam int BOUND  = 600;

    logic              clk = 1'b0;
    logic              reset_n;
    logic              job_valid;
    logic              job_ready;
    logic [LEN_W-1:0]  job_len;
    logic              elem_valid;
    logic              elem_ready;
    logic [DATA_W-1:0] elem_a;
    logic [DATA_W-1:0] elem_b;
    logic              res_valid;
    logic              res_ready;
    logic [DATA_W-1:0] res_data;
    logic              res_err;
    logic              ci_clk_en;
    logic              ci_start;
    logic [7:0]        ci_n;
    logic [DATA_W-1:0] ci_dataa;
    logic [DATA_W-1:0] ci_datab;
    logic              ci_done;
    logic [DATA_W-1:0] ci_result;

    ci_dot_initiator #(
        .DATA_W  (DATA_W),
        .LEN_W   (LEN_W),
        .TMO_CYC (255)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .job_valid  (job_valid),
        .job_ready  (job_ready),
        .job_len    (job_len),
        .elem_valid (elem_valid),
        .elem_ready (elem_ready),
        .elem_a     (elem_a),
        .elem_b     (elem_b),
        .res_valid  (res_valid),
        .res_ready  (res_ready),
        .res_data   (res_data),
        .res_err    (res_err),
        .ci_clk_en  (ci_clk_en),
        .ci_start   (ci_start),
        .ci_n       (ci_n),
        .ci_dataa   (ci_dataa),
        .ci_datab   (ci_datab),
        .ci_done    (ci_done),
        .ci_result  (ci_result)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [DATA_W-1:0] data;
        logic              err;
    } res_t;

    int   n_checks = 0;
    int   n_errors = 0;
    res_t exp_q[$];
    logic [7:0] seen_ops[$];
    logic [DATA_W-1:0] va [8];
    logic [DATA_W-1:0] vb [8];

    // Responder state (written only by the responder process)
    int   start_cnt  = 0;
    int   stab_viol  = 0;
    int   clken_viol = 0;
    // Responder controls (written only by the main process)
    int   rsp_delay  = 1;
    int   hang_abs   = -1;

    task automatic chk_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
        end
    endtask

    // Behavioural multi-cycle MAC responder
    initial begin : p_responder
        logic              pending;
        logic              hang;
        int                cnt;
        logic [7:0]        cap_n;
        logic [DATA_W-1:0] cap_a, cap_b, acc, prod;
        pending = 1'b0; hang = 1'b0; cnt = 0; acc = '0;
        cap_n = '0; cap_a = '0; cap_b = '0;
        ci_done = 1'b0; ci_result = '0;
        forever begin
            @(posedge clk); #1;
            ci_done = 1'b0;
            if (!reset_n || (pending && (elem_ready || res_valid || job_ready)))
                pending = 1'b0;
            if (pending) begin
                if (ci_n !== cap_n || ci_dataa !== cap_a || ci_datab !== cap_b)
                    stab_viol++;
                if (!hang) begin
                    cnt--;
                    if (cnt == 0) begin
                        pending = 1'b0;
                        ci_done = 1'b1;
                        prod = cap_a * cap_b;
                        case (cap_n)
                            8'd3:    begin acc = prod;       ci_result = acc; end
                            8'd1:    begin acc = acc + prod; ci_result = acc; end
                            8'd2:    begin ci_result = acc;  acc = '0;        end
                            default: ci_result = '0;
                        endcase
                    end
                end
            end
            if (ci_clk_en !== ci_start) clken_viol++;
            if (ci_start === 1'b1) begin
                if (pending) stab_viol++;
                start_cnt++;
                seen_ops.push_back(ci_n);
                cap_n = ci_n; cap_a = ci_dataa; cap_b = ci_datab;
                pending = 1'b1;
                cnt = rsp_delay;
                hang = (start_cnt == hang_abs);
            end
        end
    end

    task automatic send_job(input int len);
        int n = 0;
        job_len = LEN_W'(len);
        job_valid = 1'b1;
        while (job_ready !== 1'b1 && n < BOUND) begin @(posedge clk); #1; n++; end
        if (n >= BOUND) chk_val("job_ready_bound", 64'd0, 64'd1);
        @(posedge clk); #1;
        job_valid = 1'b0;
    endtask

    task automatic send_elem(input logic [DATA_W-1:0] a, input logic [DATA_W-1:0] b);
        int n = 0;
        elem_a = a; elem_b = b;
        elem_valid = 1'b1;
        while (elem_ready !== 1'b1 && n < BOUND) begin @(posedge clk); #1; n++; end
        if (n >= BOUND) chk_val("elem_ready_bound", 64'd0, 64'd1);
        @(posedge clk); #1;
        elem_valid = 1'b0;
    endtask

    task automatic wait_result(input string tag, input int hold);
        int   n = 0;
        res_t e;
        e.data = '0; e.err = 1'b0;
        while (res_valid !== 1'b1 && n < BOUND) begin @(posedge clk); #1; n++; end
        if (n >= BOUND) chk_val({tag, "_res_bound"}, 64'd0, 64'd1);
        if (exp_q.size() == 0) chk_val({tag, "_unexpected"}, 64'd1, 64'd0);
        else e = exp_q.pop_front();
        for (int i = 0; i < hold; i++) begin
            chk_val({tag, "_hold"}, {30'd0, res_valid, job_ready, res_data},
                    {30'd0, 1'b1, 1'b0, e.data});
            @(posedge clk); #1;
        end
        chk_val({tag, "_data"}, 64'(res_data), 64'(e.data));
        chk_val({tag, "_err"}, 64'(res_err), 64'(e.err));
        res_ready = 1'b1;
        @(posedge clk); #1;
        res_ready = 1'b0;
        chk_val({tag, "_clr"}, {62'd0, res_valid, res_err}, 64'd0);
    endtask

    // hang_k: index (1-based) of the start the responder never answers, 0 = none
    task automatic run_job(input string tag, input int len, input int delay,
                           input int hang_k, input int hold);
        int                base = seen_ops.size();
        int                sv0  = stab_viol;
        int                nops;
        logic [7:0]        eop;
        logic [DATA_W-1:0] sum = '0;
        logic [DATA_W-1:0] p;
        res_t              e;
        for (int i = 0; i < len; i++) begin p = va[i] * vb[i]; sum = sum + p; end
        e.data = (hang_k != 0) ? '0 : sum;
        e.err  = (hang_k != 0);
        exp_q.push_back(e);
        rsp_delay = delay;
        hang_abs  = (hang_k != 0) ? start_cnt + hang_k : -1;
        send_job(len);
        if (len == 0) chk_val({tag, "_zero_lat"}, 64'(res_valid), 64'd1);
        for (int i = 0; i < len; i++) send_elem(va[i], vb[i]);
        wait_result(tag, hold);
        nops = (hang_k != 0) ? hang_k : ((len > 0) ? len + 1 : 0);
        chk_val({tag, "_nops"}, 64'(seen_ops.size() - base), 64'(nops));
        for (int i = 0; i < nops && base + i < seen_ops.size(); i++) begin
            eop = (i == 0) ? 8'd3 : ((hang_k == 0 && i == len) ? 8'd2 : 8'd1);
            chk_val({tag, "_op"}, 64'(seen_ops[base + i]), 64'(eop));
        end
        chk_val({tag, "_stable"}, 64'(stab_viol - sv0), 64'd0);
    endtask

    initial begin : p_main
        reset_n = 1'b0; job_valid = 1'b0; job_len = '0; elem_valid = 1'b0;
        elem_a = '0; elem_b = '0; res_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk_val("rst_ctrl", {58'd0, job_ready, elem_ready, res_valid, res_err, ci_start, ci_clk_en}, 64'd0);
        chk_val("rst_ci_n", 64'(ci_n), 64'd0);
        chk_val("rst_res_data", 64'(res_data), 64'd0);
        reset_n = 1'b1;
        @(posedge clk); #1;
        chk_val("idle_job_ready", 64'(job_ready), 64'd1);

        va[0] = 32'd2; vb[0] = 32'd3;
        va[1] = 32'd4; vb[1] = 32'd5;
        va[2] = 32'hFFFF_FFFF; vb[2] = 32'd7;
        run_job("dot3", 3, 1, 0, 0);

        run_job("len0", 0, 1, 0, 0);

        va[0] = 32'h0001_0000; vb[0] = 32'h0001_0000;
        va[1] = 32'd1; vb[1] = 32'd1;
        run_job("wrap", 2, 5, 0, 0);

        va[0] = 32'd1; vb[0] = 32'd2;
        va[1] = 32'd3; vb[1] = 32'd4;
        va[2] = 32'd5; vb[2] = 32'd6;
        va[3] = 32'd7; vb[3] = 32'd8;
        run_job("tmo", 4, 1, 2, 0);
        va[0] = 32'd6; vb[0] = 32'd7;
        run_job("after_tmo", 1, 1, 0, 0);

        va[0] = 32'd9; vb[0] = 32'd9;
        run_job("hold", 1, 1, 0, 10);

        // Abandon a job mid-WAIT with an asynchronous reset
        rsp_delay = 20; hang_abs = -1;
        send_job(2);
        send_elem(32'd5, 32'd5);
        repeat (3) @(posedge clk);
        #2;
        reset_n = 1'b0;
        #1;
        chk_val("async_rst_ctrl", {58'd0, job_ready, elem_ready, res_valid, res_err, ci_start, ci_clk_en}, 64'd0);
        chk_val("async_rst_ci", {24'd0, ci_n, ci_dataa}, 64'd0);
        chk_val("async_rst_data", {ci_datab, res_data}, 64'd0);
        @(posedge clk); #1;
        reset_n = 1'b1;
        va[0] = 32'd3; vb[0] = 32'd3;
        run_job("post_rst", 1, 1, 0, 0);

        chk_val("clk_en_only_with_start", 64'(clken_viol), 64'd0);
        chk_val("scoreboard_empty", 64'(exp_q.size()), 64'd0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

    initial begin : p_guard
        #2_000_000;
        $display("FAIL global_timeout: simulation did not finish, expected completion");
        $fatal(1);
    end

endmodule

`default_nettype wire
